dmem_responder: RTL

//  Responder (memory side) of the CPU data-memory interface: accepts word

---
 rtl/dmem_responder_if.sv | 30 +++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory bus between the core load/store path (master) and the memory
// responder (slave). It carries the request and response valid/ready pairs.
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata/req_be    : store data and byte enables
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : load data and error flag
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data-memory bus. It accepts one word
// load or store, waits WAIT_STATES extra cycles, performs the access on an
// internal word RAM, and then returns exactly one response.
// Ports:
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : dmem_responder_if.slave (request and response handshakes)
//   access_cnt, err_cnt : completed responses and erroring responses,
//     both saturating. These ports exist only when DMEM_RESP_PERF_EN is
//     defined.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
`ifdef DMEM_RESP_PERF_EN
  ,
  output logic [15:0]     access_cnt,
  output logic [15:0]     err_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [32:0] END_ADDR = 33'(BASE_ADDR) + 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_d;
  logic               req_ready_q;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               accept;
  logic               rsp_fire;
  logic               mem_we;

  // Request latched at accept.
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;

  logic [31:0]        mem [DEPTH_WORDS];
  logic [31:0]        off;
  logic [IDX_W-1:0]   idx;
  logic               acc_err;
  logic               wait_done;

  // Address decode of the latched request.
  assign off       = addr_q - 32'(BASE_ADDR);
  assign idx       = IDX_W'(off >> 2);
  assign acc_err   = (addr_q[1:0] != 2'b00) || (addr_q < 32'(BASE_ADDR)) ||
                     ({1'b0, addr_q} >= END_ADDR);
  assign wait_done = (wait_cnt == CNT_W'(WAIT_STATES));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic. WAIT lasts WAIT_STATES+1 cycles, so rsp_valid rises
  // WAIT_STATES+1 edges after the accept edge.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (bus.req_valid) state_n = S_WAIT;
      S_WAIT:  if (wait_done)     state_n = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Output logic. Produces the next values of the registered outputs and
  // the RAM write strobe.
  always_comb begin
    accept      = 1'b0;
    rsp_fire    = 1'b0;
    mem_we      = 1'b0;
    wait_cnt_d  = wait_cnt;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state)
      S_IDLE: begin
        accept     = bus.req_valid;
        wait_cnt_d = '0;
      end
      S_WAIT: begin
        if (wait_done) begin
          mem_we      = we_q && !acc_err;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (we_q || acc_err) ? 32'h0 : mem[idx];
        end else begin
          wait_cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_fire    = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output, counter and request-capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      wait_cnt    <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
    end else begin
      req_ready_q <= (state_n == S_IDLE);
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt    <= wait_cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        be_q    <= bus.req_be;
      end
    end
  end

  // Word RAM with byte-lane writes. This block has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef DMEM_RESP_PERF_EN
  // Saturating counts of completed response handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      access_cnt <= 16'h0;
      err_cnt    <= 16'h0;
    end else if (rsp_fire) begin
      if (access_cnt != 16'hFFFF) access_cnt <= access_cnt + 16'h1;
      if (rsp_err_q && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'h1;
    end
  end
`endif

endmodule
